// File: rtl/chain_pkg.sv
// Shared types and default parameters for the chain deserializer and its output slot.
// Purely declarative: no logic, no latency, no flow control.
package chain_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chain_state_t;

    localparam int             CHAIN_WORD_W      = 8;
    localparam logic [7:0]     CHAIN_SYNC        = 8'hA5;
    localparam int             CHAIN_FRAME_WORDS = 4;

endpackage

// File: rtl/chain_word_slot.sv
// One-entry valid/ready holding register; a load becomes valid on the same edge.
// A load into a busy slot (valid & !ready) is dropped and sets sticky overflow.
module chain_word_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overflow
);

    logic slot_free;

    assign slot_free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load && slot_free) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            // A drop on the same edge as a clear must still be reported.
            if (load && !slot_free) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/chain_deserializer.sv
// Sync-word hunt and word assembly over the chain stage's serial bit; word valid on the final-bit edge.
// Output is a one-entry slot: a word completing into a busy slot is dropped and flags overflow.
module chain_deserializer
    import chain_pkg::*;
#(
    parameter int               WIDTH       = CHAIN_WORD_W,
    parameter logic [WIDTH-1:0] SYNC_WORD   = CHAIN_SYNC,
    parameter int               FRAME_WORDS = CHAIN_FRAME_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             word_ready,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    output logic             locked,
    output logic             overflow,
    output logic             frame_done
);

    localparam int BW  = $clog2(WIDTH);
    localparam int FW  = $clog2(WIDTH + 1);
    localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [BW-1:0]  BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [FW-1:0]  FILL_MAX  = FW'(WIDTH);
    localparam logic [FW-1:0]  FILL_NEED = FW'(WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    chain_state_t     state;
    logic [WIDTH-2:0] shreg;
    logic [FW-1:0]    fill;
    logic [BW-1:0]    bit_cnt;
    logic [WCW-1:0]   word_cnt;

    logic [WIDTH-1:0] cand;
    logic             word_done;

    // Only the newest WIDTH-1 bits are kept; the incoming bit completes the window.
    assign cand      = {shreg, bit_in};
    assign word_done = bit_en && (state == LOCKED) && (bit_cnt == BIT_LAST);
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            shreg      <= '0;
            fill       <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (bit_en) begin
                shreg <= cand[WIDTH-2:0];
                case (state)
                    HUNT: begin
                        if (fill != FILL_MAX) begin
                            fill <= fill + FW'(1);
                        end
                        if ((fill >= FILL_NEED) && (cand == SYNC_WORD)) begin
                            state    <= LOCKED;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (word_cnt == WORD_LAST) begin
                                // Frame end: the next sync must be built from fresh bits.
                                state      <= HUNT;
                                fill       <= '0;
                                word_cnt   <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + WCW'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    chain_word_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (word_done),
        .load_data (cand),
        .ready     (word_ready),
        .clear_ovf (clear_ovf),
        .data      (word_data),
        .valid     (word_valid),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_chain_deserializer.sv
// Directed bench for chain_deserializer: sync hunt, framing, handshake, overflow and reset.
module tb_chain_deserializer;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_en;
    logic       word_ready;
    logic       clear_ovf;
    logic [7:0] word_data;
    logic       word_valid;
    logic       locked;
    logic       overflow;
    logic       frame_done;

    int tests;
    int fails;

    chain_deserializer #(
        .WIDTH       (8),
        .SYNC_WORD   (8'hA5),
        .FRAME_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .word_ready (word_ready),
        .clear_ovf  (clear_ovf),
        .word_data  (word_data),
        .word_valid (word_valid),
        .locked     (locked),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Sends the top n bits of v, MSB first.
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_en = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        bit_en     = 1'b0;
        bit_in     = 1'b0;
        word_ready = 1'b0;
        clear_ovf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({word_data, word_valid, locked, overflow, frame_done} !== 12'h000) begin
            fails++;
            $display("FAIL reset_state: got %h/%b%b%b%b want 00/0000", word_data, word_valid, locked, overflow, frame_done);
        end
        // Build up state, then pull reset in mid-cycle.
        send_bits(8'hA5, 8);
        send_bits(8'h11, 8);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({word_data, word_valid, locked, overflow, frame_done} !== 12'h000) begin
            fails++;
            $display("FAIL async_reset: got %h/%b%b%b%b want 00/0000", word_data, word_valid, locked, overflow, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(8'hA5, 7);
        idle(3);
        tests++;
        if (locked !== 1'b0) begin
            fails++;
            $display("FAIL seven_bits_no_lock: locked got %b want 0", locked);
        end
    endtask

    task automatic test_sync_data();
        int early;
        do_reset();
        word_ready = 1'b1;
        send_bits(8'hA5, 8);
        tests++;
        if (locked !== 1'b1 || word_valid !== 1'b0) begin
            fails++;
            $display("FAIL sync_lock: locked/valid got %b/%b want 1/0", locked, word_valid);
        end
        early = 0;
        for (int i = 7; i >= 1; i--) begin
            send_bit(1'(8'h3C >> i));
            if (word_valid !== 1'b0) early++;
        end
        send_bit(1'b0);
        tests++;
        if (early != 0 || word_valid !== 1'b1 || word_data !== 8'h3C) begin
            fails++;
            $display("FAIL first_word: early=%0d valid=%b data=%h want 0/1/3c", early, word_valid, word_data);
        end
        idle(1);
        tests++;
        if (word_valid !== 1'b0) begin
            fails++;
            $display("FAIL valid_drop: got %b want 0", word_valid);
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] f1 [4];
        logic [7:0] f2 [4];
        f1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        f2 = '{8'h01, 8'h02, 8'h03, 8'h5A};
        do_reset();
        word_ready = 1'b1;
        send_bits(8'hA5, 8);
        for (int i = 0; i < 4; i++) begin
            send_bits(f1[i], 8);
            tests++;
            if (word_valid !== 1'b1 || word_data !== f1[i] || frame_done !== (i == 3) || locked !== (i != 3)) begin
                fails++;
                $display("FAIL frame_word%0d: valid=%b data=%h done=%b locked=%b want 1/%h/%b/%b",
                         i, word_valid, word_data, frame_done, locked, f1[i], (i == 3), (i != 3));
            end
        end
        idle(1);
        tests++;
        if (frame_done !== 1'b0 || word_valid !== 1'b0) begin
            fails++;
            $display("FAIL frame_done_pulse: done/valid got %b/%b want 0/0", frame_done, word_valid);
        end
        send_bits(8'hA5, 7);
        tests++;
        if (locked !== 1'b0) begin
            fails++;
            $display("FAIL relock_early: locked got %b want 0", locked);
        end
        send_bit(1'b1);
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL relock: locked got %b want 1", locked);
        end
        // Frame ending in 5A: its tail plus 0101 forms A5 with only 4 fresh bits.
        for (int i = 0; i < 4; i++) send_bits(f2[i], 8);
        send_bits(8'h50, 4);
        tests++;
        if (locked !== 1'b0) begin
            fails++;
            $display("FAIL stale_sync: locked got %b want 0", locked);
        end
        send_bits(8'hA5, 7);
        tests++;
        if (locked !== 1'b0) begin
            fails++;
            $display("FAIL stale_sync2: locked got %b want 0", locked);
        end
        send_bit(1'b1);
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL fresh_sync: locked got %b want 1", locked);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_bits(8'hA5, 8);
        send_bits(8'h5A, 8);
        tests++;
        if (word_valid !== 1'b1 || word_data !== 8'h5A || overflow !== 1'b0) begin
            fails++;
            $display("FAIL bp_first: valid=%b data=%h ovf=%b want 1/5a/0", word_valid, word_data, overflow);
        end
        send_bits(8'hC3, 8);
        tests++;
        if (word_valid !== 1'b1 || word_data !== 8'h5A || overflow !== 1'b1 || locked !== 1'b1) begin
            fails++;
            $display("FAIL bp_drop: valid=%b data=%h ovf=%b locked=%b want 1/5a/1/1", word_valid, word_data, overflow, locked);
        end
        send_bits(8'h77, 8);
        @(negedge clk);
        bit_en    = 1'b0;
        clear_ovf = 1'b1;
        @(posedge clk);
        #1;
        clear_ovf = 1'b0;
        tests++;
        if (overflow !== 1'b0 || word_data !== 8'h5A) begin
            fails++;
            $display("FAIL clear_ovf: ovf=%b data=%h want 0/5a", overflow, word_data);
        end
        send_bits(8'h88, 7);
        clear_ovf = 1'b1;
        send_bit(1'b0);
        clear_ovf = 1'b0;
        tests++;
        if (overflow !== 1'b1 || frame_done !== 1'b1 || word_data !== 8'h5A) begin
            fails++;
            $display("FAIL set_wins: ovf=%b done=%b data=%h want 1/1/5a", overflow, frame_done, word_data);
        end
        word_ready = 1'b1;
        idle(1);
        tests++;
        if (word_valid !== 1'b0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: valid=%b ovf=%b want 0/1", word_valid, overflow);
        end
    endtask

    task automatic test_accept_with_load();
        do_reset();
        send_bits(8'hA5, 8);
        send_bits(8'h12, 8);
        send_bits(8'h34, 7);
        tests++;
        if (word_valid !== 1'b1 || word_data !== 8'h12) begin
            fails++;
            $display("FAIL hold_first: valid=%b data=%h want 1/12", word_valid, word_data);
        end
        word_ready = 1'b1;
        send_bit(1'b0);
        tests++;
        if (word_valid !== 1'b1 || word_data !== 8'h34 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL accept_load: valid=%b data=%h ovf=%b want 1/34/0", word_valid, word_data, overflow);
        end
        idle(1);
        tests++;
        if (word_valid !== 1'b0) begin
            fails++;
            $display("FAIL accept_drain: valid got %b want 0", word_valid);
        end
        word_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int seen;
        do_reset();
        send_bits(8'hA5, 8);
        send_bits(8'h9A, 8);
        send_bits(8'hBC, 8);
        tests++;
        if (word_valid !== 1'b1 || word_data !== 8'h9A || overflow !== 1'b1 || locked !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: valid=%b data=%h ovf=%b locked=%b want 1/9a/1/1", word_valid, word_data, overflow, locked);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({word_data, word_valid, locked, overflow} !== 11'h000) begin
            fails++;
            $display("FAIL midframe_reset: data=%h valid=%b locked=%b ovf=%b want 00/0/0/0", word_data, word_valid, locked, overflow);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        word_ready = 1'b1;
        seen = 0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(1'((w == 0 ? 8'hDE : 8'hF0) >> i));
                if (word_valid !== 1'b0 || locked !== 1'b0) seen++;
            end
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL no_sync_no_data: %0d cycles with valid/locked high, want 0", seen);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_en     = 1'b0;
        word_ready = 1'b0;
        clear_ovf  = 1'b0;
        test_reset();
        test_sync_data();
        test_full_frame();
        test_overflow();
        test_accept_with_load();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
